// File: rtl/sevenseg_reader_if.sv
// Bus bundle between a multiplexed seven-segment source/consumer and the reader.
// master drives the segment bus and out_ready; slave is the decoder side.
interface sevenseg_reader_if;
    logic [6:0] seg;
    logic [1:0] dsel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_q;
    logic [3:0] out_s;
    logic [3:0] out_t;
    logic [2:0] blank;
    logic [2:0] err;
    logic       overrun;
    logic [7:0] err_cnt;

    modport master (
        output seg, dsel, out_ready,
        input  out_valid, out_q, out_s, out_t, blank, err, overrun, err_cnt
    );

    modport slave (
        input  seg, dsel, out_ready,
        output out_valid, out_q, out_s, out_t, blank, err, overrun, err_cnt
    );
endinterface

// File: rtl/sevenseg_reader.sv
// Debounces a multiplexed 3-digit seven-segment bus and presents decoded Q/S/T frames.
// Optional SEVENSEG_ERRCNT_EN builds a saturating counter of invalid-pattern captures.
module sevenseg_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sevenseg_reader_if.slave  bus
);
    typedef enum logic {COLLECT, PRESENT} state_t;

    typedef struct packed {
        logic [3:0] val;
        logic       blank;
        logic       err;
    } digit_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    state_t     state, state_nxt;
    logic [8:0] cur, smp;
    logic [3:0] cnt, cnt_nxt;
    logic       cap;
    digit_t     dec;
    digit_t     shadow [3];
    logic [2:0] mask, mask_set;
    logic       mask_full;
    logic       load, drop;
    logic [3:0] q_r, s_r, t_r;
    logic [2:0] blank_r, err_r;
    logic       overrun_r;

    function automatic digit_t decode(input logic [6:0] s);
        digit_t d;
        d = '{val: 4'h0, blank: 1'b0, err: 1'b0};
        case (s)
            7'h40: d.val = 4'h0;
            7'h79: d.val = 4'h1;
            7'h24: d.val = 4'h2;
            7'h30: d.val = 4'h3;
            7'h19: d.val = 4'h4;
            7'h12: d.val = 4'h5;
            7'h02: d.val = 4'h6;
            7'h78: d.val = 4'h7;
            7'h00: d.val = 4'h8;
            7'h10: d.val = 4'h9;
            7'h08: d.val = 4'hA;
            7'h03: d.val = 4'hB;
            7'h46: d.val = 4'hC;
            7'h21: d.val = 4'hD;
            7'h06: d.val = 4'hE;
            7'h0E: d.val = 4'hF;
            7'h7F: d.blank = 1'b1;
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction

    assign cur       = {bus.dsel, bus.seg};
    assign mask_full = (mask == 3'b111);

    // cnt == 0 marks "no sample since reset", so the first run starts at 1.
    always_comb begin
        cnt_nxt  = 4'd1;
        if (cnt != 4'd0 && cur == smp)
            cnt_nxt = (cnt == STABLE) ? cnt : cnt + 4'd1;
        cap      = (cnt_nxt == STABLE) && (cnt != STABLE) && (bus.dsel != 2'd3);
        dec      = decode(bus.seg);
        mask_set = cap ? (3'b001 << bus.dsel) : 3'b000;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            COLLECT: begin
                if (mask_full) begin
                    load      = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (mask_full) load = 1'b1;
                    else           state_nxt = COLLECT;
                end else if (mask_full) begin
                    drop = 1'b1;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp       <= '0;
            cnt       <= '0;
            mask      <= '0;
            q_r       <= '0;
            s_r       <= '0;
            t_r       <= '0;
            blank_r   <= '0;
            err_r     <= '0;
            overrun_r <= 1'b0;
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            smp <= cur;
            cnt <= cnt_nxt;
            for (int i = 0; i < 3; i++)
                if (cap && bus.dsel == 2'(i)) shadow[i] <= dec;
            // Captures landing on the clear cycle still count toward the next frame.
            if (load || drop) mask <= mask_set;
            else              mask <= mask | mask_set;
            if (load) begin
                q_r     <= shadow[0].val;
                s_r     <= shadow[1].val;
                t_r     <= shadow[2].val;
                blank_r <= {shadow[2].blank, shadow[1].blank, shadow[0].blank};
                err_r   <= {shadow[2].err, shadow[1].err, shadow[0].err};
            end
            if (drop) overrun_r <= 1'b1;
        end
    end

`ifdef SEVENSEG_ERRCNT_EN
    logic [7:0] err_cnt_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_r <= '0;
        else if (cap && dec.err && err_cnt_r != 8'hFF)
            err_cnt_r <= err_cnt_r + 8'd1;
    end
    assign bus.err_cnt = err_cnt_r;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.out_valid = (state == PRESENT);
    assign bus.out_q     = q_r;
    assign bus.out_s     = s_r;
    assign bus.out_t     = t_r;
    assign bus.blank     = blank_r;
    assign bus.err       = err_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_sevenseg_reader.sv
// Scoreboard bench for sevenseg_reader: a per-cycle run-length reference model pushes
// expected frames; a negedge monitor pops and compares on each accepted frame.
module tb_sevenseg_reader;
    localparam int STABLE = 4;
    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] q, s, t;
        logic [2:0] blank, err;
        int         cyc;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_reader_if bus();
    sevenseg_reader #(.STABLE_CYCLES(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    frame_t     exp_q [$];
    logic [8:0] m_prev;
    bit         m_prev_ok;
    int         m_run;
    bit [2:0]   m_mask;
    logic [3:0] m_val [3];
    bit         m_blank [3];
    bit         m_err [3];
    int         m_errs;
    bit         exp_ovr;
    bit         hold_mode = 0;
    int         hold_frames = 0;
    bit         rst_v = 1;
    bit         rdy_v = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_errcnt();
`ifdef SEVENSEG_ERRCNT_EN
        return m_errs;
`else
        return 0;
`endif
    endfunction

    function automatic void ref_decode(input logic [6:0] s, output logic [3:0] v, output bit b, output bit e);
        v = 4'h0;
        b = (s == 7'h7F);
        e = !b;
        for (int i = 0; i < 16; i++)
            if (PAT[i] == s) begin
                v = 4'(i);
                e = 1'b0;
            end
    endfunction

    function automatic void model_reset();
        m_prev_ok = 0;
        m_run     = 0;
        m_mask    = 3'b000;
        m_errs    = 0;
        exp_ovr   = 0;
    endfunction

    function automatic void model_step(input logic [1:0] d, input logic [6:0] s);
        frame_t f;
        if (m_prev_ok && {d, s} == m_prev) m_run++;
        else                              m_run = 1;
        m_prev    = {d, s};
        m_prev_ok = 1;
        if (m_run == STABLE && d != 2'd3) begin
            ref_decode(s, m_val[d], m_blank[d], m_err[d]);
            if (m_err[d] && m_errs < 255) m_errs++;
            m_mask[d] = 1'b1;
            if (m_mask == 3'b111) begin
                m_mask = 3'b000;
                if (hold_mode && hold_frames > 0) begin
                    exp_ovr = 1;
                end else begin
                    f.q     = m_val[0];
                    f.s     = m_val[1];
                    f.t     = m_val[2];
                    f.blank = {m_blank[2], m_blank[1], m_blank[0]};
                    f.err   = {m_err[2], m_err[1], m_err[0]};
                    f.cyc   = hold_mode ? -1 : cyc + 2;
                    exp_q.push_back(f);
                end
                hold_frames++;
            end
        end
    endfunction

    task automatic step(input logic [1:0] d, input logic [6:0] s);
        @(posedge clk);
        #1;
        rst           = rst_v;
        bus.dsel      = d;
        bus.seg       = s;
        bus.out_ready = rdy_v;
        if (rst_v) model_reset();
        else       model_step(d, s);
    endtask

    task automatic hold(input logic [1:0] d, input logic [6:0] s, input int n);
        repeat (n) step(d, s);
    endtask

    task automatic send_frame(input logic [6:0] sq, input logic [6:0] ss, input logic [6:0] st);
        hold(2'd0, sq, STABLE);
        hold(2'd1, ss, STABLE);
        hold(2'd2, st, STABLE);
        hold(2'd3, 7'h7F, 2);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(2'd3, 7'h7F);
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (rst === 1'b0 && bus.out_valid && bus.out_ready) begin
            chk("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                chk("out_q", bus.out_q, f.q);
                chk("out_s", bus.out_s, f.s);
                chk("out_t", bus.out_t, f.t);
                chk("blank", bus.blank, f.blank);
                chk("err", bus.err, f.err);
                if (f.cyc >= 0) chk("latency", cyc, f.cyc);
            end
        end
    end

    initial begin
        logic [6:0] s;
        rst = 1'b1;
        bus.seg = 7'h7F;
        bus.dsel = 2'd3;
        bus.out_ready = 1'b1;
        model_reset();
        repeat (3) step(2'd3, 7'h7F);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_q", {bus.out_q, bus.out_s, bus.out_t}, 0);
        chk("rst_flags", {bus.blank, bus.err, bus.overrun}, 0);
        chk("rst_errcnt", bus.err_cnt, 0);
        rst_v = 0;

        // basic frame
        send_frame(7'h30, 7'h12, 7'h0E);
        drain();
        chk("basic_q", bus.out_q, 4'h3);
        chk("basic_s", bus.out_s, 4'h5);
        chk("basic_t", bus.out_t, 4'hF);
        chk("basic_flags", {bus.blank, bus.err}, 0);

        // short glitch runs must not capture
        hold(2'd0, 7'h24, 3); hold(2'd0, 7'h79, 1); hold(2'd0, 7'h24, 4);
        hold(2'd1, 7'h24, 3); hold(2'd3, 7'h7F, 1); hold(2'd1, 7'h19, 4);
        hold(2'd2, 7'h24, 3); hold(2'd2, 7'h02, 1); hold(2'd2, 7'h24, 3);
        hold(2'd3, 7'h7F, 6);
        chk("glitch_no_frame", bus.out_valid, 0);
        hold(2'd2, 7'h24, 4); hold(2'd3, 7'h7F, 2);
        drain();
        chk("glitch_t", bus.out_t, 4'h2);

        // blank and invalid patterns
        send_frame(7'h7F, 7'h55, 7'h00);
        drain();
        chk("bl_blank", bus.blank, 3'b001);
        chk("bl_err", bus.err, 3'b010);
        chk("bl_t", bus.out_t, 4'h8);
        chk("bl_errcnt", bus.err_cnt, exp_errcnt());

        // randomized runs
        for (int r = 0; r < 300; r++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 7)       s = PAT[$urandom_range(0, 15)];
            else if (k == 7) s = 7'h7F;
            else             s = 7'($urandom);
            hold(2'($urandom_range(0, 3)), s, $urandom_range(1, 6));
        end
        hold(2'd3, 7'h7F, 2);
        drain();
        chk("rand_overrun", bus.overrun, exp_ovr);
        chk("rand_errcnt", bus.err_cnt, exp_errcnt());

        // back-pressure: second frame is dropped
        hold_mode = 1;
        hold_frames = 0;
        rdy_v = 0;
        send_frame(7'h79, 7'h24, 7'h30);
        hold(2'd3, 7'h7F, 3);
        chk("bp_valid", bus.out_valid, 1);
        send_frame(7'h19, 7'h12, 7'h02);
        hold(2'd3, 7'h7F, 3);
        chk("bp_overrun", bus.overrun, exp_ovr);
        chk("bp_overrun_set", bus.overrun, 1);
        chk("bp_held", {bus.out_q, bus.out_s, bus.out_t}, 12'h123);
        chk("bp_valid_held", bus.out_valid, 1);
        rdy_v = 1;
        step(2'd3, 7'h7F);
        hold_mode = 0;
        step(2'd3, 7'h7F);
        chk("bp_drop", bus.out_valid, 0);
        chk("bp_popped", exp_q.size(), 0);

        // reset mid-frame discards partial captures
        hold(2'd0, 7'h30, STABLE);
        hold(2'd1, 7'h12, STABLE);
        rst_v = 1;
        step(2'd3, 7'h7F);
        #1;
        chk("mrst_outs", {bus.out_q, bus.out_s, bus.out_t}, 0);
        chk("mrst_flags", {bus.out_valid, bus.blank, bus.err, bus.overrun}, 0);
        chk("mrst_errcnt", bus.err_cnt, 0);
        step(2'd3, 7'h7F);
        rst_v = 0;
        hold(2'd2, 7'h0E, STABLE);
        hold(2'd3, 7'h7F, 6);
        chk("mrst_no_valid", bus.out_valid, 0);
        chk("mrst_no_frame", exp_q.size(), 0);

        // many invalid captures saturate the error counter
        for (int i = 0; i < 256; i++) hold(2'd0, (i % 2 == 0) ? 7'h55 : 7'h56, STABLE);
        hold(2'd3, 7'h7F, 2);
        chk("sat_errcnt", bus.err_cnt, exp_errcnt());
`ifdef SEVENSEG_ERRCNT_EN
        chk("sat_errcnt_255", bus.err_cnt, 8'hFF);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
